kalman_ch_scheduler: RTL

- Time-multiplexes one Kalman update engine (predict / gain / update) across N_CH gyro measurement channels.
- Holds per-channel filter state (x, p) and per-channel noise configuration (Q, R).
- Picks pending channels round-robin, runs the engine through a start/done handshake, and writes the results back.
- Sits between the per-axis ADC sample front ends and the single shared divider/multiplier engine.

---
 rtl/kalman_ch_scheduler_pkg.sv | 28 ++
 rtl/kalman_ch_scheduler_rr_arbiter.sv | 37 +++
 rtl/kalman_ch_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/kalman_ch_scheduler_pkg.sv
// kalman_pkg: shared constants for the Kalman channel scheduler.
//   - datapath widths (14-bit measurement, 32-bit filter state)
//   - default filter constants (P_INIT, Q, R)
//   - FSM state encoding and configuration register select codes
//   - idx_w(): width of a channel index for a given channel count
package kalman_pkg;

  localparam int MEAS_W  = 14;
  localparam int STATE_W = 32;

  localparam logic [STATE_W-1:0] KAL_P_INIT = 32'd100000;
  localparam logic [STATE_W-1:0] KAL_Q_DEF  = 32'd1;
  localparam logic [STATE_W-1:0] KAL_R_DEF  = 32'd100;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_WB    = 2'd3;

  localparam logic [1:0] CFG_Q      = 2'd0;
  localparam logic [1:0] CFG_R      = 2'd1;
  localparam logic [1:0] CFG_REINIT = 2'd2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kalman_ch_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req   - request vector, one bit per channel
//   ptr   - channel with highest priority this cycle
//   gnt   - one-hot grant of the first request at or after ptr (wrapping)
//   idx   - encoded index of the granted channel
//   found - at least one request is present
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  // One bit wider than the index so ptr + i cannot overflow before the wrap.
  logic [IW:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!found && req[pos[IW-1:0]]) begin
        found             = 1'b1;
        gnt[pos[IW-1:0]]  = 1'b1;
        idx               = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/kalman_ch_scheduler.sv
// kalman_ch_scheduler: shares one Kalman update engine among N_CH channels.
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_meas_valid/i_meas    per-channel sample strobes and 14-bit samples
//   i_cfg_*                per-channel Q / R write and state reinit
//   o_eng_*, i_eng_*       engine request and result
//   o_x, o_p               per-channel filter state
//   o_upd_valid/o_upd_ch   writeback pulse and channel
//   o_overrun, o_timeout   sticky error flags
//   o_dbg_state            current FSM state
//
// Engine handshake: o_eng_start is a one-cycle pulse; the o_eng_* operand
// buses are valid from that cycle and held until the run ends. The engine
// answers with a single-cycle i_eng_done carrying i_eng_x / i_eng_p; done is
// only accepted while waiting, so stray or late pulses are dropped. A run
// with no done within TIMEOUT cycles is abandoned.
module kalman_ch_scheduler
  import kalman_pkg::*;
#(
  parameter int                 N_CH    = 3,
  parameter logic [STATE_W-1:0] P_INIT  = KAL_P_INIT,
  parameter logic [STATE_W-1:0] Q_DEF   = KAL_Q_DEF,
  parameter logic [STATE_W-1:0] R_DEF   = KAL_R_DEF,
  parameter int                 TIMEOUT = 63
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_CH-1:0]           i_meas_valid,
  input  logic [MEAS_W*N_CH-1:0]    i_meas,
  input  logic                      i_cfg_we,
  input  logic [2:0]                i_cfg_ch,
  input  logic [1:0]                i_cfg_sel,
  input  logic [31:0]               i_cfg_data,
  output logic                      o_eng_start,
  output logic [MEAS_W-1:0]         o_eng_meas,
  output logic [STATE_W-1:0]        o_eng_x,
  output logic [STATE_W-1:0]        o_eng_p,
  output logic [STATE_W-1:0]        o_eng_q,
  output logic [STATE_W-1:0]        o_eng_r,
  input  logic                      i_eng_done,
  input  logic [STATE_W-1:0]        i_eng_x,
  input  logic [STATE_W-1:0]        i_eng_p,
  output logic [STATE_W*N_CH-1:0]   o_x,
  output logic [STATE_W*N_CH-1:0]   o_p,
  output logic                      o_upd_valid,
  output logic [2:0]                o_upd_ch,
  output logic [N_CH-1:0]           o_overrun,
  output logic                      o_timeout,
  output logic [1:0]                o_dbg_state
);

  localparam int IW = idx_w(N_CH);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]         state;
  logic [IW-1:0]      ptr, sel, sel_next, gnt_idx, cfg_idx;
  logic [CW-1:0]      cnt;
  logic [N_CH-1:0]    pending, gnt;
  logic               gnt_any, grant_now, cfg_hit;
  logic [STATE_W-1:0] res_x, res_p;

  logic [MEAS_W-1:0]  meas_buf [N_CH];
  logic [STATE_W-1:0] x_q [N_CH];
  logic [STATE_W-1:0] p_q [N_CH];
  logic [STATE_W-1:0] q_q [N_CH];
  logic [STATE_W-1:0] r_q [N_CH];

  rr_arbiter #(.N(N_CH), .IW(IW)) u_arb (
    .req   (pending),
    .ptr   (ptr),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .found (gnt_any)
  );

  assign grant_now   = (state == ST_IDLE) && gnt_any;
  assign sel_next    = (sel == IW'(N_CH - 1)) ? '0 : sel + IW'(1);
  assign cfg_idx     = i_cfg_ch[IW-1:0];
  assign cfg_hit     = i_cfg_we && ({29'd0, i_cfg_ch} < 32'(N_CH));
  assign o_dbg_state = state;

  // Sample capture. The pending flag of the granted channel drops on the
  // grant edge, when its buffer is copied onto the engine bus; a strobe on
  // that channel from then on is a fresh sample, not an overrun.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending   <= '0;
      o_overrun <= '0;
      for (int c = 0; c < N_CH; c++) meas_buf[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (i_meas_valid[c]) begin
          meas_buf[c] <= i_meas[c*MEAS_W +: MEAS_W];
          pending[c]  <= 1'b1;
          if (pending[c] && !(grant_now && gnt[c])) o_overrun[c] <= 1'b1;
        end else if (grant_now && gnt[c]) begin
          pending[c] <= 1'b0;
        end
      end
    end
  end

  // Scheduler FSM and engine interface.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      sel         <= '0;
      cnt         <= '0;
      o_eng_start <= 1'b0;
      o_eng_meas  <= '0;
      o_eng_x     <= '0;
      o_eng_p     <= '0;
      o_eng_q     <= '0;
      o_eng_r     <= '0;
      res_x       <= '0;
      res_p       <= '0;
      o_upd_valid <= 1'b0;
      o_upd_ch    <= '0;
      o_timeout   <= 1'b0;
    end else begin
      o_eng_start <= 1'b0;
      o_upd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            // Operands are latched here so they stay stable for the whole
            // run, whatever config or sample traffic arrives meanwhile.
            sel         <= gnt_idx;
            o_eng_meas  <= meas_buf[gnt_idx];
            o_eng_x     <= x_q[gnt_idx];
            o_eng_p     <= p_q[gnt_idx];
            o_eng_q     <= q_q[gnt_idx];
            o_eng_r     <= r_q[gnt_idx];
            o_eng_start <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_eng_done) begin
            res_x       <= i_eng_x;
            res_p       <= i_eng_p;
            o_upd_valid <= 1'b1;
            o_upd_ch    <= 3'(sel);
            state       <= ST_WB;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            o_timeout <= 1'b1;
            ptr       <= sel_next;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WB: begin
          ptr   <= sel_next;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Per-channel state and noise config. The writeback is placed after the
  // config write so it wins over a reinit of the channel in service.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        x_q[c] <= '0;
        p_q[c] <= P_INIT;
        q_q[c] <= Q_DEF;
        r_q[c] <= R_DEF;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (cfg_hit && cfg_idx == IW'(c)) begin
          case (i_cfg_sel)
            CFG_Q:      q_q[c] <= i_cfg_data;
            CFG_R:      r_q[c] <= i_cfg_data;
            CFG_REINIT: begin
              x_q[c] <= '0;
              p_q[c] <= P_INIT;
            end
            default: ;
          endcase
        end
        if (state == ST_WB && sel == IW'(c)) begin
          x_q[c] <= res_x;
          p_q[c] <= res_p;
        end
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_out
    assign o_x[c*STATE_W +: STATE_W] = x_q[c];
    assign o_p[c*STATE_W +: STATE_W] = p_q[c];
  end

endmodule
